// File: rtl/memory_read_req_id_queue_if.sv
// rtl/memory_read_req_id_queue_if.sv - push, AR-head and retire signals of the read-request ID queue
interface memory_read_req_id_queue_if #(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32
);
  logic                  push;
  logic [ADDR_WIDTH-1:0] pushAddr;
  logic [ID_WIDTH-1:0]   pushId;
  logic                  full;
  logic                  headValid;
  logic                  headReady;
  logic [ADDR_WIDTH-1:0] headAddr;
  logic [ID_WIDTH-1:0]   headId;
  logic                  retire;
  logic [ID_WIDTH-1:0]   retireId;
  logic [ID_WIDTH:0]     count;
  logic                  empty;

  modport master (
    output push, pushAddr, headReady, retire, retireId,
    input  pushId, full, headValid, headAddr, headId, count, empty
  );

  modport slave (
    input  push, pushAddr, headReady, retire, retireId,
    output pushId, full, headValid, headAddr, headId, count, empty
  );
endinterface

// File: rtl/memory_read_req_id_queue.sv
// rtl/memory_read_req_id_queue.sv - read-request buffer allocating AXI read IDs; optional MEMORY_READ_REQ_ID_QUEUE_BYPASS_EN
module memory_read_req_id_queue #(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32
) (
  input logic                       clk,
  input logic                       rst,
  memory_read_req_id_queue_if.slave port
);
  localparam int ENTRY_NUM = 2**ID_WIDTH;

  // An ID is PENDING when neither free nor issued.
  logic [ENTRY_NUM-1:0]  free_q;
  logic [ENTRY_NUM-1:0]  issued_q;
  logic [ADDR_WIDTH-1:0] addr_q [ENTRY_NUM];
  logic [ID_WIDTH-1:0]   fifo_q [ENTRY_NUM];
  logic [ID_WIDTH-1:0]   head_ptr;
  logic [ID_WIDTH-1:0]   tail_ptr;
  logic [ID_WIDTH:0]     fifo_cnt;
  logic [ID_WIDTH:0]     count_q;

  logic [ID_WIDTH-1:0]   alloc_id;
  logic                  full;
  logic                  fifo_empty;
  logic                  push_ok;
  logic                  pop;
  logic                  fifo_wr;
  logic                  retire_ok;
  logic                  bypass_take;

  always_comb begin
    alloc_id = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_id = ID_WIDTH'(i);
    end
  end

  assign full       = ~|free_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign push_ok    = port.push && !full;
  assign retire_ok  = port.retire && issued_q[port.retireId];

  always_comb begin
    port.headValid = !fifo_empty;
    port.headId    = fifo_q[head_ptr];
    port.headAddr  = addr_q[fifo_q[head_ptr]];
    bypass_take    = 1'b0;
`ifdef MEMORY_READ_REQ_ID_QUEUE_BYPASS_EN
    if (fifo_empty && push_ok) begin
      port.headValid = 1'b1;
      port.headId    = alloc_id;
      port.headAddr  = port.pushAddr;
      bypass_take    = port.headReady;
    end
`endif
  end

  // Only real FIFO entries pop; a bypassed request never enters the FIFO.
  assign pop     = !fifo_empty && port.headReady;
  assign fifo_wr = push_ok && !bypass_take;

  assign port.pushId = alloc_id;
  assign port.full   = full;
  assign port.count  = count_q;
  assign port.empty  = (count_q == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      free_q   <= '1;
      issued_q <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      fifo_cnt <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        free_q[alloc_id] <= 1'b0;
        if (bypass_take) issued_q[alloc_id] <= 1'b1;
      end
      if (fifo_wr) tail_ptr <= tail_ptr + ID_WIDTH'(1);
      if (pop) begin
        issued_q[port.headId] <= 1'b1;
        head_ptr              <= head_ptr + ID_WIDTH'(1);
      end
      if (retire_ok) begin
        free_q[port.retireId]   <= 1'b1;
        issued_q[port.retireId] <= 1'b0;
      end
      fifo_cnt <= fifo_cnt + (ID_WIDTH+1)'(fifo_wr) - (ID_WIDTH+1)'(pop);
      count_q  <= count_q + (ID_WIDTH+1)'(push_ok) - (ID_WIDTH+1)'(retire_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) addr_q[alloc_id] <= port.pushAddr;
    if (fifo_wr) fifo_q[tail_ptr] <= alloc_id;
  end

  always_ff @(posedge clk) begin
    if (rst && port.retire) begin
      retire_legal: assert (issued_q[port.retireId])
        else $warning("retire of id %0d ignored: id not issued", port.retireId);
    end
  end
endmodule

// File: doc/memory_read_req_id_queue.md
Name: memory_read_req_id_queue

Overview:
- Parametrised read-request buffer between the cache miss handlers and the AXI4 AR channel.
- Each accepted request gets a unique AXI read ID from a free pool. Requests are presented to AR in push order.
- The ID stays allocated until the matching R-burst completes. Completions may arrive out of order, so in-flight tracking is generalised beyond a fixed-depth FIFO.

Parameters:
- ID_WIDTH, 2, AXI read ID width; entry count ENTRY_NUM = 2**ID_WIDTH.
- ADDR_WIDTH, 32, request address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low; asserted when 0.
- push  in  1  enqueue request this cycle.
- pushAddr  in  ADDR_WIDTH  address of pushed request.
- pushId  out  ID_WIDTH  ID the push is allocated this cycle (combinational, valid when !full).
- full  out  1  no free ID; push ignored.
- headValid  out  1  an un-issued request is available for AR.
- headReady  in  1  AR slave accepts head.
- headAddr  out  ADDR_WIDTH  address of oldest un-issued request.
- headId  out  ID_WIDTH  ID of oldest un-issued request.
- retire  in  1  R-burst with RLAST completed.
- retireId  in  ID_WIDTH  ID being freed.
- count  out  ID_WIDTH+1  number of allocated IDs (pending + issued).
- empty  out  1  count==0.

Behaviour:
- Per-ID state: FREE, PENDING, or ISSUED. Backed by a free bitmap, an addr array[ENTRY_NUM], and an issue-order circular FIFO of IDs (depth ENTRY_NUM, head/tail ptrs ID_WIDTH bits, wrap naturally, separate occupancy counter).
- Reset (rst==0 at clk edge):
  - all IDs FREE, issue FIFO empty, count=0.
  - Outputs: full=0, empty=1, headValid=0, pushId=0.
  - headAddr/headId don't-care.
  - Reset mid-burst discards all state; later retires of stale IDs are ignored.
- Allocation:
  - pushId = lowest-indexed FREE ID in the registered bitmap.
  - On push && !full at edge: that ID goes FREE->PENDING, addr stored, ID appended to the issue FIFO.
  - push while full: no state change.
- Issue:
  - headValid = issue FIFO non-empty.
  - headAddr/headId come from the FIFO head.
  - On headValid && headReady: FIFO pops, ID goes PENDING->ISSUED.
  - headAddr/headId hold while headValid && !headReady (AXI stability).
- Retire:
  - On retire: retireId ISSUED->FREE at edge.
  - retire of a FREE or PENDING ID is ignored, and a simulation assertion fires.
- Latency (macro off): push at edge N -> headValid=1 from cycle N+1. retire at edge N -> ID allocatable from cycle N+1.
- full and empty derive from registered state only. A same-cycle retire does not unblock a push in that cycle.
- Simultaneous push+retire: both take effect; count unchanged.
- Simultaneous push+pop+retire: all three take effect; FIFO occupancy unchanged when push and pop coincide.
- count = (push accepted ? 1:0) - (retire valid ? 1:0) applied each edge. Must never exceed ENTRY_NUM or underflow.
- Issue-FIFO occupancy never exceeds ENTRY_NUM, because FIFO entries are a subset of allocated IDs.

Optional Feature:
- Macro: MEMORY_READ_REQ_ID_QUEUE_BYPASS_EN.
- Defined, and issue FIFO empty:
  - push && !full drives headValid=1 in the same cycle, with headAddr=pushAddr and headId=pushId.
  - If headReady is also 1, the ID goes FREE->ISSUED directly and the FIFO is not written.
  - If headReady is 0, the normal enqueue happens.
- Undefined: no combinational path from push/pushAddr to head outputs; one-cycle minimum latency.

Test Plan (ID_WIDTH=2, ADDR_WIDTH=32):
- Reset then idle -> full=0, empty=1, headValid=0, count=0, pushId=0.
- Push 0x1000, 0x2000, 0x3000 on consecutive cycles with headReady=0 -> pushIds 0,1,2; count=3. Then headReady=1 for 3 cycles -> head (0x1000,0),(0x2000,1),(0x3000,2) in order; headValid=0 after.
- Fill 4 entries and issue all -> full=1; push 0x5000 ignored, count=4. Retire ID 2 -> full=0 next cycle, pushId=2. Push 0x5000 -> headId=2, headAddr=0x5000.
- Out-of-order retire 3,0,1 after 4 issued -> count 4→3→2→1. Next push gets ID 0.
- Full with push and retire(1) in same cycle -> push rejected, count=3, pushId=1 next cycle.
- Retire of FREE ID 3 after reset -> no state change, assertion fires. With BYPASS_EN, push 0x8000 with headReady=1 on empty queue -> headValid=1 same cycle, headId=0, count=1, FIFO stays empty.
